poly_tone_synth: RTL



---
 rtl/poly_tone_synth.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/poly_tone_synth.sv
// poly_tone_synth: polyphonic square-wave tone generator with a single PWM audio pin.
// Key edges are synchronised, queued per key, and serviced one per cycle onto a pool
// of tone voices. Active square outputs are summed and converted to a PWM duty.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, a press with no free voice
// steals the oldest voice. When it is undefined, that press is dropped and drop_pulse fires.
`timescale 1ns/1ps
module poly_tone_synth #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned NUM_KEYS   = 16,
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned PWM_W      = 8,
   parameter int unsigned DIV_W      = 24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_KEYS-1:0]   keys,
   output logic                  audio_out,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic                  drop_pulse
);

   localparam int unsigned KEY_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int unsigned ROM_N   = 1 << KEY_W;
   localparam int unsigned VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int unsigned LVL_W   = $clog2(NUM_VOICES + 1);
   localparam int unsigned STEP    = ((2 ** PWM_W) - 1) / NUM_VOICES;
   localparam logic [PWM_W-1:0] PWM_MAX = '1;

   // Note frequency of the lowest octave, in centi-Hz.
   function automatic longint unsigned note_chz(input int unsigned n);
      case (n)
         0:       return 64'd26163;
         1:       return 64'd27718;
         2:       return 64'd29366;
         3:       return 64'd31113;
         4:       return 64'd32963;
         5:       return 64'd34923;
         6:       return 64'd36999;
         7:       return 64'd39200;
         8:       return 64'd41530;
         9:       return 64'd44000;
         10:      return 64'd46616;
         default: return 64'd49388;
      endcase
   endfunction

   // Half-period minus one for key k; evaluated at elaboration only.
   function automatic logic [DIV_W-1:0] hp_m1(input int unsigned k);
      longint unsigned num;
      longint unsigned den;
      num = 64'(CLK_HZ) * 64'd50;
      den = note_chz(k % 12) << (k / 12);
      return DIV_W'((num / den) - 64'd1);
   endfunction

   // Constant half-period ROM, padded to a power of two so any key index is in range.
   logic [DIV_W-1:0] hp_rom [ROM_N];
   for (genvar k = 0; k < ROM_N; k++) begin : g_rom
      if (k < NUM_KEYS) begin : g_key
         assign hp_rom[k] = hp_m1(k);
      end else begin : g_pad
         assign hp_rom[k] = '0;
      end
   end

   logic [NUM_KEYS-1:0] sync1_q, sync2_q, prev_q;
   logic [NUM_KEYS-1:0] pend_press_q, pend_press_d;
   logic [NUM_KEYS-1:0] pend_rel_q, pend_rel_d;
   logic [NUM_KEYS-1:0] rise, fall, press_clr, rel_clr;
   logic                svc_rel, svc_press;
   logic [KEY_W-1:0]    svc_key;

   logic [KEY_W-1:0]      key_q [NUM_VOICES];
   logic [KEY_W-1:0]      key_d [NUM_VOICES];
   logic [DIV_W-1:0]      cnt_q [NUM_VOICES];
   logic [DIV_W-1:0]      cnt_d [NUM_VOICES];
   logic [NUM_VOICES-1:0] sq_q, sq_d, act_q, act_d;
   logic                  drop_q, drop_d;
   logic                  rel_hit, free_hit, do_assign;
   logic [VOICE_W-1:0]    free_idx, tgt;

   logic [LVL_W-1:0] level;
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
   logic             audio_q, audio_d;

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

   // Pick the event to service: lowest pending release, else lowest pending press.
   always_comb begin
      svc_rel   = 1'b0;
      svc_press = 1'b0;
      svc_key   = '0;
      for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
         if (pend_press_q[i]) begin
            svc_press = 1'b1;
            svc_key   = KEY_W'(i);
         end
      end
      if (|pend_rel_q) begin
         svc_press = 1'b0;
         svc_rel   = 1'b1;
         for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (pend_rel_q[i]) svc_key = KEY_W'(i);
         end
      end
   end

   // Clear the serviced bit; a fresh edge in the same cycle re-sets it.
   always_comb begin
      press_clr    = '0;
      rel_clr      = '0;
      if (svc_press) press_clr = NUM_KEYS'(1) << svc_key;
      if (svc_rel)   rel_clr   = NUM_KEYS'(1) << svc_key;
      pend_press_d = (pend_press_q & ~press_clr) | rise;
      pend_rel_d   = (pend_rel_q & ~rel_clr) | fall;
   end

   // Key synchroniser, edge history and pending-event vectors.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         prev_q       <= '0;
         pend_press_q <= '0;
         pend_rel_q   <= '0;
      end else begin
         sync1_q      <= keys;
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         pend_press_q <= pend_press_d;
         pend_rel_q   <= pend_rel_d;
      end
   end

`ifdef VOICE_STEAL_EN
   localparam int unsigned AGE_W = 8;
   logic [AGE_W-1:0]   age_q [NUM_VOICES];
   logic [AGE_W-1:0]   age_d [NUM_VOICES];
   logic [AGE_W-1:0]   best_age;
   logic [VOICE_W-1:0] oldest;

   // Oldest voice: highest age, ties resolved toward the lowest index.
   always_comb begin
      oldest   = '0;
      best_age = age_q[0];
      for (int v = 1; v < int'(NUM_VOICES); v++) begin
         if (age_q[v] > best_age) begin
            best_age = age_q[v];
            oldest   = VOICE_W'(v);
         end
      end
   end

   // Every allocation ages the other active voices and zeroes the allocated one.
   always_comb begin
      age_d = age_q;
      if (do_assign) begin
         for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (VOICE_W'(v) == tgt) age_d[v] = '0;
            else if (act_q[v] && (age_q[v] != '1)) age_d[v] = age_q[v] + AGE_W'(1);
         end
      end
   end

   // Voice ages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int v = 0; v < int'(NUM_VOICES); v++) age_q[v] <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`endif

   // Tone voices: half-period counters plus the one event applied this cycle.
   always_comb begin
      key_d     = key_q;
      cnt_d     = cnt_q;
      sq_d      = sq_q;
      act_d     = act_q;
      drop_d    = 1'b0;
      rel_hit   = 1'b0;
      free_hit  = 1'b0;
      free_idx  = '0;
      tgt       = '0;
      do_assign = 1'b0;
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
         if (act_q[v]) begin
            if (cnt_q[v] == hp_rom[key_q[v]]) begin
               cnt_d[v] = '0;
               sq_d[v]  = ~sq_q[v];
            end else begin
               cnt_d[v] = cnt_q[v] + DIV_W'(1);
            end
         end
      end
      if (svc_rel) begin
         for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (!rel_hit && act_q[v] && (key_q[v] == svc_key)) begin
               rel_hit  = 1'b1;
               act_d[v] = 1'b0;
               cnt_d[v] = '0;
               sq_d[v]  = 1'b0;
            end
         end
      end
      for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
         if (!act_q[v]) begin
            free_hit = 1'b1;
            free_idx = VOICE_W'(v);
         end
      end
      if (svc_press) begin
         if (free_hit) begin
            tgt       = free_idx;
            do_assign = 1'b1;
         end else begin
`ifdef VOICE_STEAL_EN
            tgt       = oldest;
            do_assign = 1'b1;
`else
            drop_d    = 1'b1;
`endif
         end
      end
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
         if (do_assign && (VOICE_W'(v) == tgt)) begin
            key_d[v] = svc_key;
            cnt_d[v] = '0;
            sq_d[v]  = 1'b1;
            act_d[v] = 1'b1;
         end
      end
   end

   // Voice state and drop pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int v = 0; v < int'(NUM_VOICES); v++) begin
            key_q[v] <= '0;
            cnt_q[v] <= '0;
         end
         sq_q   <= '0;
         act_q  <= '0;
         drop_q <= 1'b0;
      end else begin
         key_q  <= key_d;
         cnt_q  <= cnt_d;
         sq_q   <= sq_d;
         act_q  <= act_d;
         drop_q <= drop_d;
      end
   end

   // Mixer: number of voices currently high.
   always_comb begin
      level = '0;
      for (int v = 0; v < int'(NUM_VOICES); v++) level = level + LVL_W'(sq_q[v]);
   end

   // PWM: duty reloads on the last count of each frame.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      duty_d    = duty_q;
      if (pwm_cnt_q == PWM_MAX) duty_d = PWM_W'(level * STEP);
      audio_d   = (pwm_cnt_q < duty_q);
   end

   // PWM counter, duty and output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         audio_q   <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         audio_q   <= audio_d;
      end
   end

   assign audio_out    = audio_q;
   assign voice_active = act_q;
   assign drop_pulse   = drop_q;

endmodule
